// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial LSB-first adder built from two half-adder cells per
//            bit plus a registered carry; start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             p;
  logic             g;
  logic             s;
  logic             t;
  logic             carry_next;
  logic             last;
  logic [WIDTH-1:0] work_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    p          = sa[0] ^ sb[0];
    g          = sa[0] & sb[0];
    s          = p ^ carry;
    t          = p & carry;
    carry_next = g | t;
    last       = (cnt == LAST_BIT);
    busy       = (state == RUN);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The working register holds only the bits already produced; the bit
  // computed this cycle is appended combinationally to form the full word.
  generate
    if (WIDTH == 1) begin : g_w1
      assign work_next = s;
    end else begin : g_wn
      logic [WIDTH-2:0] acc;
      always_ff @(posedge clk) begin
        if (rst || (state != RUN)) begin
          acc <= '0;
        end else begin
          acc <= work_next[WIDTH-1:1];
        end
      end
      assign work_next = {s, acc};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= work_next;
            cout <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Scoreboard bench for serial_adder at WIDTH = 8, 1 and 16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0, start1 = 1'b0, start16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        a1 = 1'b0, b1 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy8, done8, cout8, busy1, done1, cout1, busy16, done16, cout16;
  logic [7:0]  sum8;
  logic        sum1;
  logic [15:0] sum16;

  int vectors = 0;
  int errors  = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] q2[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );
  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  function automatic int width_of(input int d);
    case (d)
      0:       return 8;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [32:0] res_of(input int d);
    case (d)
      0:       return {24'd0, cout8, sum8};
      1:       return {31'd0, cout1, sum1};
      default: return {16'd0, cout16, sum16};
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return busy8;
      1:       return busy1;
      default: return busy16;
    endcase
  endfunction

  function automatic logic done_of(input int d);
    case (d)
      0:       return done8;
      1:       return done1;
      default: return done16;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic [31:0] x, input logic [31:0] y);
    case (d)
      0:       begin start8  = st; a8  = x[7:0];  b8  = y[7:0];  end
      1:       begin start1  = st; a1  = x[0];    b1  = y[0];    end
      default: begin start16 = st; a16 = x[15:0]; b16 = y[15:0]; end
    endcase
  endtask

  // Issue one addition; optionally re-pulse start with other operands
  // after edge pulse_at to confirm it is ignored.
  task automatic run_op(input int d, input logic [31:0] x, input logic [31:0] y,
                        input int pulse_at, input bit timing);
    int          w;
    logic [32:0] m;
    logic [32:0] exp;
    w   = width_of(d);
    m   = (33'd1 << w) - 33'd1;
    exp = ({1'b0, x} & m) + ({1'b0, y} & m);
    case (d)
      0:       q0.push_back(exp);
      1:       q1.push_back(exp);
      default: q2.push_back(exp);
    endcase
    @(negedge clk);
    drive(d, 1'b1, x, y);
    @(posedge clk);
    for (int k = 0; k <= w + 1; k++) begin
      @(negedge clk);
      if (k == pulse_at) drive(d, 1'b1, 32'hAA, 32'h55);
      else               drive(d, 1'b0, $urandom, $urandom);
      if (timing) begin
        chk($sformatf("busy w%0d after edge %0d", w, k), {32'd0, busy_of(d)}, {32'd0, (k < w)});
        chk($sformatf("done w%0d after edge %0d", w, k), {32'd0, done_of(d)}, {32'd0, (k == w)});
      end
    end
    drive(d, 1'b0, 32'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q0.size() == 0) begin
        vectors++; errors++;
        $display("FAIL done w8: got unexpected done, required no pending result (t=%0t)", $time);
      end else begin
        chk("result w8", {24'd0, cout8, sum8}, q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        vectors++; errors++;
        $display("FAIL done w1: got unexpected done, required no pending result (t=%0t)", $time);
      end else begin
        chk("result w1", {31'd0, cout1, sum1}, q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q2.size() == 0) begin
        vectors++; errors++;
        $display("FAIL done w16: got unexpected done, required no pending result (t=%0t)", $time);
      end else begin
        chk("result w16", {16'd0, cout16, sum16}, q2.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset busy d%0d", d), {32'd0, busy_of(d)}, 33'd0);
      chk($sformatf("reset done d%0d", d), {32'd0, done_of(d)}, 33'd0);
      chk($sformatf("reset result d%0d", d), res_of(d), 33'd0);
    end
    rst = 1'b0;

    run_op(0, 32'h3C, 32'h5A, -1, 1'b1);
    run_op(0, 32'hFF, 32'h01, -1, 1'b0);
    run_op(0, 32'hFF, 32'hFF, -1, 1'b0);
    run_op(0, 32'h00, 32'h00, -1, 1'b0);

    // start during RUN is ignored; result then holds through IDLE
    run_op(0, 32'h10, 32'h20, 3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("hold sum w8", res_of(0), 33'h030);
      chk("hold idle busy w8", {32'd0, busy8}, 33'd0);
    end

    // start during DONE is ignored; an IDLE start afterwards runs normally
    run_op(0, 32'h12, 32'h34, 8, 1'b1);
    run_op(0, 32'h01, 32'h02, -1, 1'b1);

    // reset in the 4th RUN cycle aborts without a done pulse
    @(negedge clk);
    drive(0, 1'b1, 32'h80, 32'h80);
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      drive(0, 1'b0, 32'h0, 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy w8", {32'd0, busy8}, 33'd0);
    chk("abort done w8", {32'd0, done8}, 33'd0);
    chk("abort result w8", res_of(0), 33'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort stays idle w8", {32'd0, busy8}, 33'd0);
    run_op(0, 32'h80, 32'h80, -1, 1'b1);

    run_op(1, 32'h1, 32'h1, -1, 1'b1);
    run_op(1, 32'h0, 32'h1, -1, 1'b0);
    run_op(1, 32'h1, 32'h0, -1, 1'b0);
    run_op(1, 32'h0, 32'h0, -1, 1'b0);

    run_op(2, 32'hFFFF, 32'h0001, -1, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      run_op(2, 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)), -1, 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("pending w8", 33'(q0.size()), 33'd0);
    chk("pending w1", 33'(q1.size()), 33'd0);
    chk("pending w16", 33'(q2.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
